// File: rtl/pc_pkg.sv
// Shared types and constants for the PC sequencer.
//   pc_state_e  : sequencer FSM states (BOOT, RUN, HALTED)
//   INSTR_BYTES : bytes per instruction
//   fetch_bytes : bytes per fetch group for a given fetch width
package pc_pkg;

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } pc_state_e;

  localparam int unsigned INSTR_BYTES = 4;

  // Address increment for one fetch group.
  function automatic int unsigned fetch_bytes(input int unsigned fetch_width);
    return INSTR_BYTES * fetch_width;
  endfunction

endpackage

// File: rtl/redirect_arbiter.sv
// Fixed-priority redirect selector; source 0 has the highest priority.
//   redir_valid_i : per-source request
//   redir_pc_i    : per-source target, source k in [k*XLEN +: XLEN]
//   any_valid_o   : at least one source is requesting
//   sel_idx_o     : index of the winning source (0 when none)
//   sel_pc_o      : target of the winning source (0 when none)
module redirect_arbiter #(
  parameter int unsigned NUM_REDIR = 3,
  parameter int unsigned XLEN      = 32,
  localparam int unsigned IDX_W    = (NUM_REDIR > 1) ? $clog2(NUM_REDIR) : 1
) (
  input  logic [NUM_REDIR-1:0]      redir_valid_i,
  input  logic [NUM_REDIR*XLEN-1:0] redir_pc_i,
  output logic                      any_valid_o,
  output logic [IDX_W-1:0]          sel_idx_o,
  output logic [XLEN-1:0]           sel_pc_o
);

  // Walk from the lowest priority upward so the lowest asserted index wins.
  always_comb begin
    any_valid_o = 1'b0;
    sel_idx_o   = '0;
    sel_pc_o    = '0;
    for (int k = int'(NUM_REDIR) - 1; k >= 0; k--) begin
      if (redir_valid_i[k]) begin
        any_valid_o = 1'b1;
        sel_idx_o   = IDX_W'(k);
        sel_pc_o    = redir_pc_i[k*XLEN +: XLEN];
      end
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch program-counter sequencer with prioritised redirects and epoch tagging.
//   clk, reset_n   : clock, asynchronous active-low reset
//   stall          : hold PC, drop fetch_valid
//   halt           : enter HALTED (sampled in RUN only)
//   redir_valid/pc : per-source redirect requests and targets
//   fetch_ready    : instruction memory accepts the current group
//   fetch_valid    : pc_out is a valid fetch request (combinational)
//   pc_out         : current fetch-group address
//   epoch          : redirect generation tag
//   redir_taken    : pulse, a redirect was applied on the last edge
//   misaligned_err : pulse, the applied target had non-zero bits [1:0]
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(32'h0000_0000),
  parameter int unsigned     FETCH_WIDTH  = 1,
  parameter int unsigned     NUM_REDIR    = 3,
  parameter int unsigned     EPOCH_W      = 2
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      stall,
  input  logic                      halt,
  input  logic [NUM_REDIR-1:0]      redir_valid,
  input  logic [NUM_REDIR*XLEN-1:0] redir_pc,
  input  logic                      fetch_ready,
  output logic                      fetch_valid,
  output logic [XLEN-1:0]           pc_out,
  output logic [EPOCH_W-1:0]        epoch,
  output logic                      redir_taken,
  output logic                      misaligned_err
);

  localparam int unsigned     IDX_W      = (NUM_REDIR > 1) ? $clog2(NUM_REDIR) : 1;
  localparam logic [XLEN-1:0] PC_STEP    = XLEN'(fetch_bytes(FETCH_WIDTH));
  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(INSTR_BYTES - 1);

  pc_state_e          state_q, state_d;
  logic [XLEN-1:0]    pc_q, pc_d;
  logic [EPOCH_W-1:0] epoch_q, epoch_d;
  logic               redir_taken_q, redir_taken_d;
  logic               misaligned_q, misaligned_d;

  logic               any_valid;
  logic [IDX_W-1:0]   sel_idx;
  logic [XLEN-1:0]    sel_pc;
  logic [1:0]         sel_lsb;
  logic               fire_c;

  redirect_arbiter #(
    .NUM_REDIR (NUM_REDIR),
    .XLEN      (XLEN)
  ) u_arb (
    .redir_valid_i (redir_valid),
    .redir_pc_i    (redir_pc),
    .any_valid_o   (any_valid),
    .sel_idx_o     (sel_idx),
    .sel_pc_o      (sel_pc)
  );

  // Alignment bits of the winning source only; losing sources never flag.
  assign sel_lsb = redir_pc[int'(sel_idx)*XLEN +: 2];

  assign fetch_valid = (state_q == RUN) && !stall;
  assign fire_c      = fetch_valid && fetch_ready;

  // Next state: a redirect overrides everything, in every state.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    epoch_d       = epoch_q;
    redir_taken_d = 1'b0;
    misaligned_d  = 1'b0;
    if (any_valid) begin
      state_d       = RUN;
      pc_d          = sel_pc & ALIGN_MASK;
      epoch_d       = epoch_q + EPOCH_W'(1);
      redir_taken_d = 1'b1;
      misaligned_d  = |sel_lsb;
    end else begin
      case (state_q)
        BOOT: state_d = RUN;
        RUN: begin
          // Halt takes precedence over an accepted fetch; the PC is frozen.
          if (halt) begin
            state_d = HALTED;
          end else if (fire_c) begin
            pc_d = pc_q + PC_STEP;
          end
        end
        HALTED: state_d = HALTED;
        default: state_d = BOOT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= BOOT;
      pc_q          <= RESET_VECTOR;
      epoch_q       <= '0;
      redir_taken_q <= 1'b0;
      misaligned_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      epoch_q       <= epoch_d;
      redir_taken_q <= redir_taken_d;
      misaligned_q  <= misaligned_d;
    end
  end

  assign pc_out         = pc_q;
  assign epoch          = epoch_q;
  assign redir_taken    = redir_taken_q;
  assign misaligned_err = misaligned_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: one instance with FETCH_WIDTH=1 and one
// with FETCH_WIDTH=4, both driven by the same stimulus.
module tb_pc_sequencer;

  logic        clk;
  logic        reset_n;
  logic        stall;
  logic        halt;
  logic [2:0]  redir_valid;
  logic [95:0] redir_pc;
  logic        fetch_ready;

  logic        fv1, rt1, me1;
  logic [31:0] pc1;
  logic [1:0]  ep1;
  logic        fv4, rt4, me4;
  logic [31:0] pc4;
  logic [1:0]  ep4;

  int n_chk;
  int n_bad;

  pc_sequencer u_dut1 (
    .clk            (clk),
    .reset_n        (reset_n),
    .stall          (stall),
    .halt           (halt),
    .redir_valid    (redir_valid),
    .redir_pc       (redir_pc),
    .fetch_ready    (fetch_ready),
    .fetch_valid    (fv1),
    .pc_out         (pc1),
    .epoch          (ep1),
    .redir_taken    (rt1),
    .misaligned_err (me1)
  );

  pc_sequencer #(.FETCH_WIDTH(4)) u_dut4 (
    .clk            (clk),
    .reset_n        (reset_n),
    .stall          (stall),
    .halt           (halt),
    .redir_valid    (redir_valid),
    .redir_pc       (redir_pc),
    .fetch_ready    (fetch_ready),
    .fetch_valid    (fv4),
    .pc_out         (pc4),
    .epoch          (ep4),
    .redir_taken    (rt4),
    .misaligned_err (me4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_redir(input logic [2:0] v, input logic [31:0] p0,
                           input logic [31:0] p1, input logic [31:0] p2);
    redir_valid = v;
    redir_pc    = {p2, p1, p0};
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    repeat (2) step();
    reset_n = 1'b1;
  endtask

  logic [31:0] tgt [4];
  logic [1:0]  exp_ep [4];

  initial begin
    n_chk = 0;
    n_bad = 0;
    reset_n     = 1'b0;
    stall       = 1'b0;
    halt        = 1'b0;
    fetch_ready = 1'b1;
    set_redir(3'b000, 32'h0, 32'h0, 32'h0);

    // Reset values
    repeat (3) step();
    chk("rst_pc", pc1, 32'h0);
    chk("rst_fv", fv1, 1'b0);
    chk("rst_ep", ep1, 2'd0);
    chk("rst_rt", rt1, 1'b0);
    chk("rst_me", me1, 1'b0);

    // Boot then sequential fetch
    reset_n = 1'b1;
    chk("boot_fv", fv1, 1'b0);
    chk("boot_pc", pc1, 32'h0);
    step();
    chk("run0_fv", fv1, 1'b1);
    chk("run0_pc", pc1, 32'h0);
    step();
    chk("run1_pc", pc1, 32'h4);
    chk("run1_pc4", pc4, 32'h10);
    step();
    chk("run2_pc", pc1, 32'h8);
    chk("run2_pc4", pc4, 32'h20);
    chk("run2_fv", fv1, 1'b1);

    // Backpressure: ready low for three cycles
    fetch_ready = 1'b0;
    do_reset();
    chk("bp_boot_fv", fv4, 1'b0);
    step();
    chk("bp_c1_pc4", pc4, 32'h0);
    chk("bp_c1_fv4", fv4, 1'b1);
    step();
    chk("bp_c2_pc4", pc4, 32'h0);
    step();
    chk("bp_c3_pc4", pc4, 32'h0);
    chk("bp_c3_pc1", pc1, 32'h0);
    fetch_ready = 1'b1;
    step();
    chk("bp_go_pc4", pc4, 32'h10);
    chk("bp_go_pc1", pc1, 32'h4);

    // Redirect beats stall; source 1 wins over source 2
    stall = 1'b1;
    set_redir(3'b110, 32'hDEAD_BEEF, 32'h1000_0000, 32'h2000_0000);
    #1;
    chk("st_fv", fv1, 1'b0);
    step();
    chk("rd_pc", pc1, 32'h1000_0000);
    chk("rd_pc4", pc4, 32'h1000_0000);
    chk("rd_ep", ep1, 2'd1);
    chk("rd_rt", rt1, 1'b1);
    chk("rd_me", me1, 1'b0);
    set_redir(3'b000, 32'h0, 32'h0, 32'h0);
    step();
    chk("rd_hold_pc", pc1, 32'h1000_0000);
    chk("rd_rt_off", rt1, 1'b0);
    chk("rd_hold_ep", ep1, 2'd1);
    stall = 1'b0;
    #1;
    chk("unst_fv", fv1, 1'b1);
    step();
    chk("unst_pc", pc1, 32'h1000_0004);
    chk("unst_pc4", pc4, 32'h1000_0010);

    // Misaligned target on the winner, then on a loser only
    set_redir(3'b001, 32'h0000_0103, 32'h0, 32'h0);
    step();
    chk("mis_pc", pc1, 32'h0000_0100);
    chk("mis_me", me1, 1'b1);
    chk("mis_ep", ep1, 2'd2);
    set_redir(3'b110, 32'h0, 32'h0000_0200, 32'h0000_0301);
    step();
    chk("los_pc", pc1, 32'h0000_0200);
    chk("los_me", me1, 1'b0);
    chk("los_rt", rt1, 1'b1);
    chk("los_ep", ep1, 2'd3);
    set_redir(3'b000, 32'h0, 32'h0, 32'h0);
    step();
    chk("post_pc", pc1, 32'h0000_0204);
    chk("post_me", me1, 1'b0);
    chk("post_rt", rt1, 1'b0);

    // Reset mid-operation takes effect before the next edge
    reset_n = 1'b0;
    #1;
    chk("mid_fv", fv1, 1'b0);
    chk("mid_pc", pc1, 32'h0);
    chk("mid_ep", ep1, 2'd0);
    step();
    chk("mid_fv2", fv1, 1'b0);
    reset_n = 1'b1;

    // Halt at pc 0x8, hold, then exit by redirect
    step();
    step();
    step();
    chk("h_pre_pc", pc1, 32'h8);
    halt = 1'b1;
    step();
    chk("h_fv", fv1, 1'b0);
    chk("h_pc", pc1, 32'h8);
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("h_hold%0d_pc", i), pc1, 32'h8);
      chk($sformatf("h_hold%0d_fv", i), fv1, 1'b0);
    end
    chk("h_ep", ep1, 2'd0);
    halt = 1'b0;
    set_redir(3'b100, 32'h0, 32'h0, 32'h0000_0040);
    step();
    chk("h_out_pc", pc1, 32'h40);
    chk("h_out_ep", ep1, 2'd1);
    chk("h_out_fv", fv1, 1'b1);
    chk("h_out_rt", rt1, 1'b1);
    set_redir(3'b000, 32'h0, 32'h0, 32'h0);
    step();
    chk("h_run_pc", pc1, 32'h44);

    // Back-to-back redirects starting in BOOT, then wrap
    do_reset();
    set_redir(3'b001, 32'h0000_0100, 32'h0, 32'h0);
    step();
    chk("b2b0_pc", pc1, 32'h100);
    chk("b2b0_ep", ep1, 2'd1);
    chk("b2b0_fv", fv1, 1'b1);
    tgt[0] = 32'h0000_0200; exp_ep[0] = 2'd2;
    tgt[1] = 32'h0000_0300; exp_ep[1] = 2'd3;
    tgt[2] = 32'h0000_0400; exp_ep[2] = 2'd0;
    tgt[3] = 32'hFFFF_FFFC; exp_ep[3] = 2'd1;
    for (int i = 0; i < 4; i++) begin
      set_redir(3'b001, tgt[i], 32'h0, 32'h0);
      step();
      chk($sformatf("b2b%0d_pc", i + 1), pc1, tgt[i]);
      chk($sformatf("b2b%0d_ep", i + 1), ep1, exp_ep[i]);
      chk($sformatf("b2b%0d_rt", i + 1), rt1, 1'b1);
    end
    set_redir(3'b000, 32'h0, 32'h0, 32'h0);
    step();
    chk("wrap_pc", pc1, 32'h0000_0000);
    chk("wrap_pc4", pc4, 32'h0000_000C);
    chk("wrap_rt", rt1, 1'b0);
    chk("wrap_ep", ep1, 2'd1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
